// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg
//   Shared types and constants for the two-master Wishbone arbiter:
//   the arbitration state encoding, the default read data returned on a
//   timeout termination, and the width of the per-transfer timeout counter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hdeadbeef;

  // Wide enough for TIMEOUT_CYCLES up to 255.
  localparam int CTR_W = 8;

endpackage

// File: rtl/wb_timeout_ctr.sv
// wb_timeout_ctr
//   Counts consecutive cycles of a granted strobe that has not been
//   acknowledged, and pulses expire on the cycle where the count reaches
//   TIMEOUT_CYCLES-1. The pulse is combinational so the arbiter can
//   terminate the transfer in that same cycle.
// Ports:
//   clk     in  1  clock
//   rst_n   in  1  asynchronous active-low reset
//   enable  in  1  granted STB high and no ACK this cycle
//   clear   in  1  restart the count (ACK, STB low or not granted)
//   expire  out 1  one-cycle timeout pulse
module wb_timeout_ctr
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expire
);

  localparam logic [CTR_W-1:0] LAST_COUNT = CTR_W'(TIMEOUT_CYCLES - 1);

  logic [CTR_W-1:0] count_reg;

  // The compare bounds the count, so it never wraps.
  assign expire = enable && (count_reg == LAST_COUNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear || expire) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// wb_arbiter_2m
//   Shares one Wishbone register slave between master 0 (management core)
//   and master 1 (debug/loader). Round-robin grant, locked for the whole
//   CYC burst, with one IDLE cycle between owners. A granted strobe that
//   waits TIMEOUT_CYCLES cycles without ACK is terminated with ERR.
// Ports:
//   wb_clk_i, wb_rst_ni            clock, asynchronous active-low reset
//   m0_* / m1_*                    master cyc/stb/we/sel/adr/dat in, ack/err/dat out
//   s_*                            slave cyc/stb/we/sel/adr/dat out, ack/dat in
//   grant_o                        one-hot owner, 00 when idle
//   timeout_irq_o, timeout_clr_i   sticky timeout flag and its clear
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_sel_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_irq_o,
  input  logic        timeout_clr_i
);

  arb_state_t state_reg;
  logic       last_owner_reg;
  logic       timeout_irq_reg;

  logic own0, own1;
  logic own_stb;
  logic expire;
  logic ctr_enable;

  // Ownership is also gated by reset so every output falls the moment
  // reset asserts, independent of the clock.
  assign own0 = wb_rst_ni && (state_reg == OWN0);
  assign own1 = wb_rst_ni && (state_reg == OWN1);

  always_comb begin
    s_cyc_o = 1'b0;
    own_stb = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (own0) begin
      s_cyc_o = m0_cyc_i;
      own_stb = m0_stb_i;
      s_we_o  = m0_we_i;
      s_sel_o = m0_sel_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (own1) begin
      s_cyc_o = m1_cyc_i;
      own_stb = m1_stb_i;
      s_we_o  = m1_we_i;
      s_sel_o = m1_sel_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  // The terminated strobe is withheld from the slave in the ERR cycle.
  assign s_stb_o = own_stb && !expire;

  // expire implies s_ack_i=0, so ACK and ERR are mutually exclusive.
  assign m0_ack_o = own0 && s_ack_i;
  assign m0_err_o = own0 && expire;
  assign m0_dat_o = own0 ? (expire ? ERR_DATA : s_dat_i) : '0;
  assign m1_ack_o = own1 && s_ack_i;
  assign m1_err_o = own1 && expire;
  assign m1_dat_o = own1 ? (expire ? ERR_DATA : s_dat_i) : '0;

  assign grant_o       = {own1, own0};
  assign timeout_irq_o = timeout_irq_reg;

  assign ctr_enable = own_stb && !s_ack_i;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .enable(ctr_enable),
    .clear (!ctr_enable),
    .expire(expire)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg       <= IDLE;
      last_owner_reg  <= 1'b1;
      timeout_irq_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (m0_cyc_i && m1_cyc_i) begin
            state_reg <= last_owner_reg ? OWN0 : OWN1;
          end else if (m0_cyc_i) begin
            state_reg <= OWN0;
          end else if (m1_cyc_i) begin
            state_reg <= OWN1;
          end
        end
        OWN0: begin
          if (!m0_cyc_i) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b0;
          end
        end
        OWN1: begin
          if (!m1_cyc_i) begin
            state_reg      <= IDLE;
            last_owner_reg <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase

      // Set has priority over a coincident clear.
      if (expire) begin
        timeout_irq_reg <= 1'b1;
      end else if (timeout_clr_i) begin
        timeout_irq_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
module tb_wb_arbiter_2m;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdat, m1_rdat;
  logic        s_cyc, s_stb, s_we, s_ack;
  logic [3:0]  s_sel;
  logic [31:0] s_adr, s_wdat, s_rdat;
  logic [1:0]  grant;
  logic        irq, clr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_arbiter_2m #(.TIMEOUT_CYCLES(16), .ERR_DATA(32'hdeadbeef)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_sel_i(m0_sel),
    .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_dat_o(m0_rdat),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_dat_o(m1_rdat),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
    .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_ack_i(s_ack), .s_dat_i(s_rdat),
    .grant_o(grant), .timeout_irq_o(irq), .timeout_clr_i(clr)
  );

  // ctl = {cyc, stb, we}; flags = {s_cyc, s_stb, s_we, m0_ack, m0_err, m1_ack, m1_err}
  typedef struct {
    logic [2:0]  m0_ctl;
    logic [31:0] m0_a;
    logic [31:0] m0_d;
    logic [2:0]  m1_ctl;
    logic [31:0] m1_a;
    logic [31:0] m1_d;
    logic        sack;
    logic [31:0] sdat;
    logic [1:0]  e_grant;
    logic [6:0]  e_flags;
    logic [31:0] e_sadr;
    logic [31:0] e_sdo;
    logic [31:0] e_m0dat;
    logic [31:0] e_m1dat;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vec [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_m0(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] d);
    {m0_cyc, m0_stb, m0_we} = ctl;
    m0_adr = a;
    m0_dat = d;
  endtask

  task automatic drive_m1(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] d);
    {m1_cyc, m1_stb, m1_we} = ctl;
    m1_adr = a;
    m1_dat = d;
  endtask

  initial begin
    // Arbitration after reset, round robin, read of BASE+4
    vec[0]  = '{3'b000, 0,           0, 3'b000, 0,          0, 0, 0,            2'b00, 7'b0000000, 0,          0, 0,            0};
    vec[1]  = '{3'b110, BASE+32'h8,  0, 3'b110, BASE+32'hc, 0, 0, 0,            2'b00, 7'b0000000, 0,          0, 0,            0};
    vec[2]  = '{3'b110, BASE+32'h8,  0, 3'b110, BASE+32'hc, 0, 1, 32'h5,        2'b01, 7'b1101000, BASE+32'h8, 0, 32'h5,        0};
    vec[3]  = '{3'b000, 0,           0, 3'b110, BASE+32'hc, 0, 0, 0,            2'b01, 7'b0000000, 0,          0, 0,            0};
    vec[4]  = '{3'b110, BASE+32'h8,  0, 3'b110, BASE+32'hc, 0, 0, 0,            2'b00, 7'b0000000, 0,          0, 0,            0};
    vec[5]  = '{3'b110, BASE+32'h8,  0, 3'b110, BASE+32'hc, 0, 1, 32'h7,        2'b10, 7'b1100010, BASE+32'hc, 0, 0,            32'h7};
    vec[6]  = '{3'b110, BASE+32'h8,  0, 3'b000, 0,          0, 0, 0,            2'b10, 7'b0000000, 0,          0, 0,            0};
    vec[7]  = '{3'b110, BASE+32'h4,  0, 3'b000, 0,          0, 0, 0,            2'b00, 7'b0000000, 0,          0, 0,            0};
    vec[8]  = '{3'b110, BASE+32'h4,  0, 3'b000, 0,          0, 0, 0,            2'b01, 7'b1100000, BASE+32'h4, 0, 0,            0};
    vec[9]  = '{3'b110, BASE+32'h4,  0, 3'b000, 0,          0, 1, 32'h4669626f, 2'b01, 7'b1101000, BASE+32'h4, 0, 32'h4669626f, 0};
    vec[10] = '{3'b000, 0,           0, 3'b000, 0,          0, 0, 0,            2'b01, 7'b0000000, 0,          0, 0,            0};
    vec[11] = '{3'b000, 0,           0, 3'b000, 0,          0, 0, 0,            2'b00, 7'b0000000, 0,          0, 0,            0};
    // m1 write burst locks out m0
    vec[12] = '{3'b110, BASE+32'h4,  0, 3'b111, BASE+32'h18, 32'ha1, 0, 0,      2'b00, 7'b0000000, 0,           0,      0, 0};
    vec[13] = '{3'b110, BASE+32'h4,  0, 3'b111, BASE+32'h18, 32'ha1, 1, 0,      2'b10, 7'b1110010, BASE+32'h18, 32'ha1, 0, 0};
    vec[14] = '{3'b110, BASE+32'h4,  0, 3'b111, BASE+32'h18, 32'ha2, 1, 0,      2'b10, 7'b1110010, BASE+32'h18, 32'ha2, 0, 0};
    vec[15] = '{3'b110, BASE+32'h4,  0, 3'b111, BASE+32'h18, 32'ha3, 1, 0,      2'b10, 7'b1110010, BASE+32'h18, 32'ha3, 0, 0};
    vec[16] = '{3'b110, BASE+32'h4,  0, 3'b000, 0,           0,      0, 0,      2'b10, 7'b0000000, 0,           0,      0, 0};
    vec[17] = '{3'b110, BASE+32'h4,  0, 3'b000, 0,           0,      0, 0,      2'b00, 7'b0000000, 0,           0,      0, 0};
    // ACK coincident with m0 dropping CYC, m1 waiting
    vec[18] = '{3'b110, BASE+32'h4,  0, 3'b110, BASE+32'h10, 0, 0, 0,           2'b01, 7'b1100000, BASE+32'h4,  0, 0,     0};
    vec[19] = '{3'b000, 0,           0, 3'b110, BASE+32'h10, 0, 1, 32'h55,      2'b01, 7'b0001000, 0,           0, 32'h55, 0};
    vec[20] = '{3'b000, 0,           0, 3'b110, BASE+32'h10, 0, 0, 0,           2'b00, 7'b0000000, 0,           0, 0,     0};
    vec[21] = '{3'b000, 0,           0, 3'b110, BASE+32'h10, 0, 0, 0,           2'b10, 7'b1100000, BASE+32'h10, 0, 0,     0};
    vec[22] = '{3'b000, 0,           0, 3'b000, 0,           0, 0, 0,           2'b10, 7'b0000000, 0,           0, 0,     0};
    vec[23] = '{3'b000, 0,           0, 3'b000, 0,           0, 0, 0,           2'b00, 7'b0000000, 0,           0, 0,     0};

    drive_m0(3'b000, 0, 0);
    drive_m1(3'b000, 0, 0);
    m0_sel = 4'hf;
    m1_sel = 4'h3;
    s_ack  = 1'b0;
    s_rdat = '0;
    clr    = 1'b0;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("reset grant", {30'd0, grant}, 0);
    chk("reset s_cyc", {31'd0, s_cyc}, 0);
    chk("reset irq", {31'd0, irq}, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven single-cycle vectors
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk);
      #1;
      drive_m0(vec[i].m0_ctl, vec[i].m0_a, vec[i].m0_d);
      drive_m1(vec[i].m1_ctl, vec[i].m1_a, vec[i].m1_d);
      s_ack  = vec[i].sack;
      s_rdat = vec[i].sdat;
      #3;
      $display("vec %0d: grant=%b s_cyc=%b s_stb=%b s_adr=%h m0_ack=%b m1_ack=%b m0_dat=%h m1_dat=%h",
               i, grant, s_cyc, s_stb, s_adr, m0_ack, m1_ack, m0_rdat, m1_rdat);
      chk($sformatf("v%0d grant", i), {30'd0, grant}, {30'd0, vec[i].e_grant});
      chk($sformatf("v%0d flags", i), {25'd0, s_cyc, s_stb, s_we, m0_ack, m0_err, m1_ack, m1_err},
          {25'd0, vec[i].e_flags});
      chk($sformatf("v%0d s_adr", i), s_adr, vec[i].e_sadr);
      chk($sformatf("v%0d s_dat", i), s_wdat, vec[i].e_sdo);
      chk($sformatf("v%0d m0_dat", i), m0_rdat, vec[i].e_m0dat);
      chk($sformatf("v%0d m1_dat", i), m1_rdat, vec[i].e_m1dat);
    end
    chk("burst s_sel idle", {28'd0, s_sel}, 0);

    // Timeout on an unmapped read with the slave silent
    @(posedge clk);
    #1 drive_m0(3'b110, BASE - 32'h4, 0);
    s_ack  = 1'b0;
    s_rdat = '0;
    #3 chk("to arb grant", {30'd0, grant}, 0);
    for (int i = 1; i <= 34; i++) begin
      logic e_err;
      logic e_irq;
      @(posedge clk);
      #1;
      clr = (i == 32 || i == 33);
      if (i == 34) drive_m0(3'b000, 0, 0);
      #3;
      e_err = (i == 16 || i == 32);
      e_irq = (i > 16 && i <= 33);
      $display("to cycle %0d: err=%b ack=%b stb=%b dat=%h irq=%b clr=%b",
               i, m0_err, m0_ack, s_stb, m0_rdat, irq, clr);
      chk($sformatf("to%0d irq", i), {31'd0, irq}, {31'd0, e_irq});
      if (i < 34) begin
        chk($sformatf("to%0d err", i), {31'd0, m0_err}, {31'd0, e_err});
        chk($sformatf("to%0d dat", i), m0_rdat, e_err ? 32'hdeadbeef : 32'h0);
        chk($sformatf("to%0d stb", i), {31'd0, s_stb}, {31'd0, !e_err});
        chk($sformatf("to%0d ack", i), {31'd0, m0_ack}, 0);
        chk($sformatf("to%0d m1_err", i), {31'd0, m1_err}, 0);
      end
    end
    clr = 1'b0;

    // Asynchronous reset in the middle of an m1 transfer
    @(posedge clk);
    #1 drive_m1(3'b110, BASE + 32'h14, 0);
    s_ack  = 1'b1;
    s_rdat = 32'h99;
    #3 chk("ar idle grant", {30'd0, grant}, 0);
    @(posedge clk);
    #3;
    $display("ar before: grant=%b s_cyc=%b s_stb=%b m1_ack=%b", grant, s_cyc, s_stb, m1_ack);
    chk("ar pre grant", {30'd0, grant}, 2'b10);
    chk("ar pre m1_ack", {31'd0, m1_ack}, 1);
    #2 rst_n = 1'b0;
    #1;
    $display("ar during: grant=%b s_cyc=%b s_stb=%b m1_ack=%b", grant, s_cyc, s_stb, m1_ack);
    chk("ar s_cyc", {31'd0, s_cyc}, 0);
    chk("ar s_stb", {31'd0, s_stb}, 0);
    chk("ar grant", {30'd0, grant}, 0);
    chk("ar m1_ack", {31'd0, m1_ack}, 0);
    @(posedge clk);
    #1 drive_m0(3'b110, BASE + 32'h4, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #3 chk("ar rel grant", {30'd0, grant}, 0);
    @(posedge clk);
    #3;
    $display("ar after: grant=%b m0_ack=%b m1_ack=%b irq=%b", grant, m0_ack, m1_ack, irq);
    chk("ar tie grant", {30'd0, grant}, 2'b01);
    chk("ar tie m0_ack", {31'd0, m0_ack}, 1);
    chk("ar tie m1_ack", {31'd0, m1_ack}, 0);
    chk("ar tie irq", {31'd0, irq}, 0);

    drive_m0(3'b000, 0, 0);
    drive_m1(3'b000, 0, 0);
    s_ack = 1'b0;
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
